// File: rtl/mac_stream.sv
// Streaming multiply-accumulate engine: one coef/sample pair per handshake,
// TAPS products summed into one result with optional saturation and overflow flag.
//
// state | meaning
// IDLE  | tap_cnt = 0, next accepted pair opens a new group
// RUN   | part of a group accepted, tap_cnt counts accepted pairs
module mac_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+3,
  parameter bit SIGNED     = 1'b0,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] coef,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  y,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW  = 2*DATA_WIDTH;
  localparam int EW  = ACC_WIDTH+1;
  localparam int CW  = (TAPS > 2) ? $clog2(TAPS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        tap_cnt_q, tap_cnt_d;
  logic                 accept, is_first, is_last;

  logic [PW-1:0]        coef_x, sample_x, prod;
  logic [PW-1:0]        p_q;
  logic                 s1_valid_q, s1_first_q, s1_last_q;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_run_q, ovf_run_d;
  logic [EW-1:0]        p_ext, acc_ext, base, sum;
  logic                 ovf_now;
  logic [ACC_WIDTH-1:0] y_q, sat_max, sat_min;
  logic                 ovf_q, out_valid_q;

  assign in_ready  = !clear && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_first  = (tap_cnt_q == '0);
  assign is_last   = (tap_cnt_q == CW'(TAPS-1));

  assign y         = y_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    if (clear) begin
      state_d   = IDLE;
      tap_cnt_d = '0;
    end else if (accept) begin
      if (is_last) begin
        state_d   = IDLE;
        tap_cnt_d = '0;
      end else begin
        state_d   = RUN;
        tap_cnt_d = tap_cnt_q + CW'(1);
      end
    end
  end

  // Extending to full product width first lets one unsigned multiply serve both signednesses.
  assign coef_x   = SIGNED ? {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef}
                           : {{DATA_WIDTH{1'b0}}, coef};
  assign sample_x = SIGNED ? {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample}
                           : {{DATA_WIDTH{1'b0}}, sample};
  assign prod     = coef_x * sample_x;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        p_q        <= prod;
        s1_first_q <= is_first;
        s1_last_q  <= is_last;
      end
    end
  end

  assign p_ext   = SIGNED ? {{(EW-PW){p_q[PW-1]}}, p_q} : {{(EW-PW){1'b0}}, p_q};
  assign acc_ext = SIGNED ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
  assign base    = s1_first_q ? '0 : acc_ext;
  assign sum     = base + p_ext;
  assign ovf_now = SIGNED ? (sum[EW-1] ^ sum[EW-2]) : sum[EW-1];
  assign sat_max = SIGNED ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  assign sat_min = SIGNED ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  always_comb begin
    acc_d     = sum[ACC_WIDTH-1:0];
    ovf_run_d = s1_first_q ? ovf_now : (ovf_run_q | ovf_now);
    if (ovf_now && SATURATE) begin
      // Bit EW-1 carries the true sign of the unclamped sum.
      acc_d = (SIGNED && sum[EW-1]) ? sat_min : sat_max;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      ovf_run_q   <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      acc_q       <= '0;
      ovf_run_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (s1_valid_q) begin
        acc_q     <= acc_d;
        ovf_run_q <= ovf_run_d;
      end
      if (s1_valid_q && s1_last_q) begin
        y_q         <= acc_d;
        ovf_q       <= ovf_run_d;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
